// File: rtl/dcache_tag_pkg.sv
// rtl/dcache_tag_pkg.sv - shared widths, tag entry layout and controller states
package dcache_tag_pkg;

  localparam int TAG_W   = 24;
  localparam int IDX_W   = 5;
  localparam int ENTRY_W = 26;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// rtl/dcache_tag_ctrl_if.sv - tag SRAM port bundle (write port 0, read port 1)
interface dcache_tag_ctrl_if;
  import dcache_tag_pkg::*;

  logic               ram_csb0;
  logic [IDX_W-1:0]   ram_addr0;
  logic [ENTRY_W-1:0] ram_din0;
  logic               ram_csb1;
  logic [IDX_W-1:0]   ram_addr1;
  logic [ENTRY_W-1:0] ram_dout1;

  modport master (
    output ram_csb0, ram_addr0, ram_din0, ram_csb1, ram_addr1,
    input  ram_dout1
  );

  modport slave (
    input  ram_csb0, ram_addr0, ram_din0, ram_csb1, ram_addr1,
    output ram_dout1
  );

endinterface

// File: rtl/dcache_tag_sweep.sv
// rtl/dcache_tag_sweep.sv - index counter shared by the reset and flush invalidate sweeps
module dcache_tag_sweep
  import dcache_tag_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             done_o
);

  logic [IDX_W-1:0] cnt_q;

  assign idx_o  = cnt_q;
  assign done_o = (cnt_q == {IDX_W{1'b1}});

  // Wraps to 0 only on the last index, which is also the cycle the sweep exits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= done_o ? '0 : cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/dcache_tag_ctrl.sv
// rtl/dcache_tag_ctrl.sv - dcache tag SRAM controller: lookup/compare, fill writes, invalidate sweeps
// DCACHE_TAG_BYPASS_EN: forward same-cycle write data to a same-index lookup instead of stalling it.
module dcache_tag_ctrl
  import dcache_tag_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lk_valid_i,
  output logic              lk_ready_o,
  input  logic [31:0]       lk_addr_i,
  output logic              rsp_valid_o,
  output logic              rsp_hit_o,
  output logic              rsp_dirty_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              wr_valid_bit_i,
  input  logic              wr_dirty_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              flush_done_o,
  dcache_tag_ctrl_if.master ram
);

  localparam logic [1:0] S_INIT  = ST_INIT;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_FLUSH = ST_FLUSH;

  logic [1:0]       state_q, state_d;
  logic             run, sweeping, sweep_start, sweep_done;
  logic [IDX_W-1:0] sweep_idx, lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             conflict, byp, lk_fire, wr_fire;
  tag_entry_t       wr_ent, rd_ent;

  logic             p_valid_q, p_byp_q;
  logic [TAG_W-1:0] p_tag_q;
  tag_entry_t       p_ent_q;
  logic             rsp_valid_q, rsp_hit_q, rsp_dirty_q, flush_done_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             unused_addr_lo;

  assign lk_idx         = lk_addr_i[IDX_W+2:3];
  assign lk_tag         = lk_addr_i[31:32-TAG_W];
  assign unused_addr_lo = ^lk_addr_i[2:0];

  assign run         = (state_q == S_RUN);
  assign sweeping    = !run;
  assign sweep_start = run && flush_i;
  assign conflict    = wr_valid_i && (wr_idx_i == lk_idx);

`ifdef DCACHE_TAG_BYPASS_EN
  assign lk_ready_o = run;
  assign byp        = conflict;
`else
  assign lk_ready_o = run && !conflict;
  assign byp        = 1'b0;
`endif

  assign wr_ready_o = run;
  assign lk_fire    = lk_valid_i && lk_ready_o;
  assign wr_fire    = wr_valid_i && run;
  assign wr_ent     = '{valid: wr_valid_bit_i, dirty: wr_dirty_i, tag: wr_tag_i};

  assign ram.ram_csb0  = !(sweeping || wr_fire);
  assign ram.ram_addr0 = sweeping ? sweep_idx : (wr_fire ? wr_idx_i : '0);
  assign ram.ram_din0  = (!sweeping && wr_fire) ? wr_ent : '0;
  // A forwarded lookup leaves the read port idle so it never collides with the write.
  assign ram.ram_csb1  = !(lk_fire && !byp);
  assign ram.ram_addr1 = (lk_fire && !byp) ? lk_idx : '0;

  dcache_tag_sweep u_sweep (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (sweep_start),
    .en_i    (sweeping),
    .idx_o   (sweep_idx),
    .done_o  (sweep_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (sweep_done) state_d = S_RUN;
      S_RUN:   if (flush_i) state_d = S_FLUSH;
      S_FLUSH: if (sweep_done) state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  assign rd_ent = p_byp_q ? p_ent_q : tag_entry_t'(ram.ram_dout1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= (state_q == S_FLUSH) && sweep_done;
    end
  end

  // Stage 1 holds the request while the SRAM reads; stage 2 registers the compare.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_valid_q   <= 1'b0;
      p_byp_q     <= 1'b0;
      p_tag_q     <= '0;
      p_ent_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_dirty_q <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      p_valid_q   <= lk_fire;
      rsp_valid_q <= p_valid_q;
      if (lk_fire) begin
        p_byp_q <= byp;
        p_tag_q <= lk_tag;
        p_ent_q <= wr_ent;
      end
      if (p_valid_q) begin
        rsp_hit_q   <= rd_ent.valid && (rd_ent.tag == p_tag_q);
        rsp_dirty_q <= rd_ent.dirty;
        rsp_tag_q   <= rd_ent.tag;
      end
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_dirty_o  = rsp_dirty_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign busy_o       = sweeping;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb/tb_dcache_tag_ctrl.sv - scoreboard bench for dcache_tag_ctrl with a behavioural tag SRAM
module tb_dcache_tag_ctrl;
  import dcache_tag_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              lk_valid = 1'b0, lk_ready;
  logic [31:0]       lk_addr = '0;
  logic              rsp_valid, rsp_hit, rsp_dirty;
  logic [TAG_W-1:0]  rsp_tag;
  logic              wr_valid = 1'b0, wr_ready;
  logic [IDX_W-1:0]  wr_idx = '0;
  logic              wr_v = 1'b0, wr_d = 1'b0;
  logic [TAG_W-1:0]  wr_tag = '0;
  logic              flush = 1'b0, busy, flush_done;

  dcache_tag_ctrl_if ram_if ();

  dcache_tag_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lk_valid_i(lk_valid), .lk_ready_o(lk_ready), .lk_addr_i(lk_addr),
    .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_dirty_o(rsp_dirty), .rsp_tag_o(rsp_tag),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_idx_i(wr_idx),
    .wr_valid_bit_i(wr_v), .wr_dirty_i(wr_d), .wr_tag_i(wr_tag),
    .flush_i(flush), .busy_o(busy), .flush_done_o(flush_done),
    .ram(ram_if)
  );

  // Tag SRAM: samples on posedge, drives read data after the following negedge.
  logic [ENTRY_W-1:0] mem [32];
  logic [IDX_W-1:0]   rd_a = '0;
  logic               rd_p = 1'b0;
  logic [ENTRY_W-1:0] dout_q = '0;
  assign ram_if.ram_dout1 = dout_q;
  always @(posedge clk) begin
    if (!ram_if.ram_csb0) mem[ram_if.ram_addr0] <= ram_if.ram_din0;
    rd_p <= !ram_if.ram_csb1;
    rd_a <= ram_if.ram_addr1;
  end
  always @(negedge clk) if (rd_p) dout_q <= mem[rd_a];

  int checks = 0, errors = 0, cyc = 0, fd_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (flush_done) fd_cnt++;

  typedef struct {
    logic        hit;
    logic        dirty;
    logic [23:0] tag;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected actual=hit%0d/tag%06h required=no response", rsp_hit, rsp_tag);
      end else begin
        e = q.pop_front();
        if ({rsp_hit, rsp_dirty, rsp_tag} !== {e.hit, e.dirty, e.tag} || cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp actual=hit%0d dirty%0d tag%06h cyc%0d required=hit%0d dirty%0d tag%06h cyc%0d",
                   rsp_hit, rsp_dirty, rsp_tag, cyc, e.hit, e.dirty, e.tag, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic h, input logic d, input logic [23:0] t);
    exp_t x;
    x.hit = h; x.dirty = d; x.tag = t; x.cyc = cyc + 1;
    q.push_back(x);
  endtask

  task automatic do_write(input logic [4:0] idx, input logic v, input logic d, input logic [23:0] t);
    int n = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_idx = idx; wr_v = v; wr_d = d; wr_tag = t;
    #1;
    while (!wr_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("wr_ready_timeout", {63'd0, wr_ready}, 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] a, input logic h, input logic d, input logic [23:0] t);
    int n = 0;
    @(negedge clk);
    lk_valid = 1'b1; lk_addr = a;
    #1;
    while (!lk_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("lk_ready_timeout", {63'd0, lk_ready}, 64'd1);
    @(posedge clk); #1;
    lk_valid = 1'b0;
    expect_rsp(h, d, t);
  endtask

  task automatic check_sweep();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("sweep_%0d", i),
          {30'd0, busy, ram_if.ram_csb0, ram_if.ram_addr0, ram_if.ram_din0},
          {30'd0, 1'b1, 1'b0, 5'(i), 26'd0});
    end
    @(negedge clk);
    chk("sweep_end busy/lk_ready/wr_ready", {61'd0, busy, lk_ready, wr_ready}, 64'b011);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #10;
    chk("rst rsp", {36'd0, rsp_valid, rsp_hit, rsp_dirty, rsp_tag}, 64'd0);
    chk("rst ready/busy/done", {60'd0, lk_ready, wr_ready, busy, flush_done}, 64'b0010);
    chk("rst ram", {22'd0, ram_if.ram_csb0, ram_if.ram_csb1, ram_if.ram_addr0, ram_if.ram_addr1, ram_if.ram_din0},
        {22'd0, 1'b0, 1'b1, 5'd0, 5'd0, 26'd0});
    @(posedge clk); #1 rst_n = 1'b1;
    check_sweep();
    repeat (2) @(negedge clk);
    chk("init_no_flush_done", 64'(fd_cnt), 64'd0);

    do_write(5'd5, 1'b1, 1'b0, 24'hABCDEF);
    do_lookup(32'hABCDEF28, 1'b1, 1'b0, 24'hABCDEF);
    do_lookup(32'h12345628, 1'b0, 1'b0, 24'hABCDEF);

    do_write(5'd9, 1'b1, 1'b1, 24'h55AA33);
    do_write(5'd10, 1'b0, 1'b1, 24'h777777);
    do_lookup(32'h55AA3348, 1'b1, 1'b1, 24'h55AA33);
    do_lookup(32'h77777750, 1'b0, 1'b1, 24'h777777);
    do_lookup(32'hABCDEF28, 1'b1, 1'b0, 24'hABCDEF);

    @(negedge clk);
    wr_valid = 1'b1; wr_idx = 5'd7; wr_v = 1'b1; wr_d = 1'b0; wr_tag = 24'h000111;
    lk_valid = 1'b1; lk_addr = 32'h00011138;
    #1;
`ifdef DCACHE_TAG_BYPASS_EN
    chk("conflict_ready", {63'd0, lk_ready}, 64'd1);
    chk("conflict_csb1", {63'd0, ram_if.ram_csb1}, 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0; lk_valid = 1'b0;
    expect_rsp(1'b1, 1'b0, 24'h000111);
`else
    chk("conflict_ready", {63'd0, lk_ready}, 64'd0);
    chk("conflict_csb0", {63'd0, ram_if.ram_csb0}, 64'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("conflict_retry_ready", {63'd0, lk_ready}, 64'd1);
    @(posedge clk); #1;
    lk_valid = 1'b0;
    expect_rsp(1'b1, 1'b0, 24'h000111);
`endif

    @(negedge clk);
    lk_valid = 1'b1; lk_addr = 32'hABCDEF28; flush = 1'b1;
    #1 chk("flush_lk_ready", {63'd0, lk_ready}, 64'd1);
    @(posedge clk); #1;
    lk_valid = 1'b0; flush = 1'b0;
    expect_rsp(1'b1, 1'b0, 24'hABCDEF);
    check_sweep();
    repeat (2) @(negedge clk);
    chk("flush_done_once", 64'(fd_cnt), 64'd1);
    do_lookup(32'hABCDEF28, 1'b0, 1'b0, 24'h000000);
    do_lookup(32'h00011138, 1'b0, 1'b0, 24'h000000);
    repeat (3) @(negedge clk);

    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (13) @(negedge clk);
    chk("mid_sweep_idx", {59'd0, ram_if.ram_addr0}, 64'd12);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst busy/addr0", {58'd0, busy, ram_if.ram_addr0}, {58'd0, 1'b1, 5'd0});
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    check_sweep();
    repeat (4) @(negedge clk);
    chk("no_done_after_abort", 64'(fd_cnt), 64'd1);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/dcache_tag_ctrl.md
# dcache_tag_ctrl

Client-side controller for the dual-port data-cache tag SRAM (32 entries × 26 bits, port 0 write-only, port 1 read-only, active-low chip selects, inputs sampled on posedge, read data driven after the following negedge). It drives both SRAM ports and accepts lookup requests from the dcache pipeline. It compares the stored tag and returns hit, dirty and victim tag. It also performs fill/update writes and a full-array invalidate sweep after reset and on flush. The SRAM macro stays a separate instance at the dcache top so it can be hardened.

## Interface
- TAG_W, 24, stored tag width (addr[31:8]).
- IDX_W, 5, index width (addr[7:3]); depth 1<<IDX_W.
- clk_i  input  1  single clock; the SRAM clk0/clk1 are both tied to it at the top.
- rst_ni  input  1  reset, asynchronous, active-low.
- lk_valid_i / lk_ready_o  in/out  1  lookup handshake; a lookup is accepted when both are high at a posedge.
- lk_addr_i  input  32  lookup address.
- rsp_valid_o  output  1  one-cycle response pulse; no backpressure.
- rsp_hit_o, rsp_dirty_o  output  1  hit is valid && tag match; dirty is the stored dirty bit.
- rsp_tag_o  output  TAG_W  stored tag (victim address for writeback).
- wr_valid_i / wr_ready_o  in/out  1  tag write handshake.
- wr_idx_i  input  IDX_W  write index.
- wr_valid_bit_i, wr_dirty_i  input  1  new entry flags.
- wr_tag_i  input  TAG_W  new entry tag.
- flush_i  input  1  invalidate-all request pulse.
- busy_o  output  1  high during a sweep.
- flush_done_o  output  1  one-cycle pulse when a flush sweep ends.
- ram_csb0_o, ram_addr0_o[IDX_W], ram_din0_o[26]  output  SRAM write port.
- ram_csb1_o, ram_addr1_o[IDX_W]  output  SRAM read port.
- ram_dout1_i  input  26  SRAM read data.

## Operation
- Entry format: din[25]=valid, din[24]=dirty, din[23:0]=tag.
- States:
  - INIT: entered on reset. Writes 0 to indices 0..31, one per cycle. Both lk_ready_o and wr_ready_o are low. After index 31 → RUN. No flush_done_o pulse for INIT.
  - RUN: lookups and writes are serviced.
  - FLUSH: entered from RUN on flush_i. Sweeps indices 0..31 like INIT. After index 31 → RUN and pulse flush_done_o.
- flush_i is ignored in INIT and FLUSH. A lookup accepted before the flush still returns its response, using pre-flush data.
- Write (RUN): drives csb0=0, addr0=wr_idx_i, din0 formed from the inputs in the same cycle. wr_ready_o = (state==RUN).
- Lookup (RUN): drives csb1=0, addr1=lk_addr_i[7:3] combinationally in the accept cycle. The tag and index are held in a 1-deep pipeline register. lk_ready_o is high in RUN, subject to the conflict rule below. Back-to-back lookups are accepted every cycle.
- Conflict: a write and a lookup to the same index in the same cycle is resolved according to Configuration.
- csb0 and csb1 are high whenever no access is issued.

## Timing
- Lookup accepted at edge E0. SRAM read data is valid after the negedge in cycle E0→E1. Compare result is registered at E1. rsp_* are visible in the cycle after E1 (2-cycle latency).
- A write accepted at E0 is visible to any lookup accepted at E1 or later.
- Reset values: rsp_valid_o=0, rsp_hit_o=0, rsp_dirty_o=0, rsp_tag_o=0, lk_ready_o=0, wr_ready_o=0, busy_o=1, flush_done_o=0, ram_csb0_o=0 (INIT write of index 0 begins), ram_csb1_o=1, ram_addr*=0, ram_din0_o=0.
- Sweep: 32 cycles. busy_o is high for exactly those cycles.
- Reset asserted mid-sweep or mid-lookup: the in-flight response is dropped and INIT restarts at index 0.
- Sweep counter wraps 31→0 only on state exit; it never wraps inside a sweep.

## Configuration
- DCACHE_TAG_BYPASS_EN defined:
  - A same-cycle same-index conflict is still accepted.
  - The response uses the write data (valid, dirty, tag) instead of ram_dout1_i, with the same 2-cycle latency.
  - ram_csb1_o stays high for that lookup to avoid the SRAM collision.
- Undefined: lk_ready_o is forced low in any cycle where wr_valid_i && wr_idx_i==lk_addr_i[7:3].

## Structure
- Package dcache_tag_pkg holds:
  - TAG_W, IDX_W, ENTRY_W=26;
  - a packed entry struct {valid, dirty, tag};
  - the state enum {INIT, RUN, FLUSH}.
- One natural sub-module: dcache_tag_sweep, a 5-bit index counter with start/done, shared by INIT and FLUSH.

## Test plan
- Reset release → 32 consecutive writes of din0=0 to indices 0..31, then lk_ready_o=1, wr_ready_o=1; no flush_done_o pulse.
- Write idx 5 {v=1,d=0,tag=0xABCDEF}, then lookup addr 0xABCDEF28 → rsp_valid_o 2 cycles after accept, hit=1, dirty=0, rsp_tag_o=0xABCDEF.
- Lookup addr 0x12345628 to the same entry → hit=0, rsp_tag_o=0xABCDEF.
- Same-cycle write idx 7 tag 0x000111 v=1 with lookup addr 0x00011138:
  - bypass build → accepted, hit=1;
  - non-bypass build → lk_ready_o=0 that cycle, then accepted next cycle with hit=1.
- flush_i with one lookup in flight → that response still hits; 32 zero writes follow; flush_done_o pulses once; a subsequent lookup of idx 5 → hit=0.
- rst_ni low at sweep index 12 → sweep restarts at index 0 and busy_o stays high for 32 cycles after release.
